// File: rtl/contador_ctrl_pkg.sv
// Shared definitions for the BCD counter run controller: state encodings and digit widths.
package contador_ctrl_pkg;

  localparam int ST_W    = 3;
  localparam int DIGIT_W = 4;
  localparam int BCD_W   = 4 * DIGIT_W;

  typedef enum logic [ST_W-1:0] {
    ST_CLR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } ctl_state_e;

endpackage

// File: rtl/contador_debounce.sv
// One-bit button filter: the output level follows the raw input only after DB_CYCLES
// consecutive samples disagree with the current level.
module contador_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt holds how many consecutive samples have differed from level so far
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= raw;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/contador_ctrl.sv
// Run controller for the 4-digit BCD counter chain: start/stop/clear buttons, prescaled ena0,
// stop at a BCD terminal count. Define DEBOUNCE_EN to filter the buttons through contador_debounce.
module contador_ctrl
  import contador_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk_ctl,
  input  logic              rstbutton_ctl,
  input  logic              start_ctl,
  input  logic              stop_ctl,
  input  logic              clear_ctl,
  input  logic [BCD_W-1:0]  limit_ctl,
  input  logic [DIGIT_W-1:0] Qdata3_ctl,
  input  logic [DIGIT_W-1:0] Qdata2_ctl,
  input  logic [DIGIT_W-1:0] Qdata1_ctl,
  input  logic [DIGIT_W-1:0] Qdata0_ctl,
  output logic              ena0_ctl,
  output logic              clr_ctl,
  output logic              running_ctl,
  output logic              done_ctl,
  output logic [ST_W-1:0]   state_ctl
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_lv, stop_lv, clear_lv;

`ifdef DEBOUNCE_EN
  contador_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk_ctl), .rst(rstbutton_ctl), .raw(start_ctl), .level(start_lv)
  );
  contador_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk_ctl), .rst(rstbutton_ctl), .raw(stop_ctl), .level(stop_lv)
  );
  contador_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk(clk_ctl), .rst(rstbutton_ctl), .raw(clear_ctl), .level(clear_lv)
  );
`else
  assign start_lv = start_ctl;
  assign stop_lv  = stop_ctl;
  assign clear_lv = clear_ctl;
`endif

  logic start_q, stop_q, clear_q;
  logic start_rise, stop_rise, clear_rise;

  always_ff @(posedge clk_ctl) begin
    if (rstbutton_ctl) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= start_lv;
      stop_q  <= stop_lv;
      clear_q <= clear_lv;
    end
  end

  assign start_rise = start_lv & ~start_q;
  assign stop_rise  = stop_lv  & ~stop_q;
  assign clear_rise = clear_lv & ~clear_q;

  logic match;
  assign match = ({Qdata3_ctl, Qdata2_ctl, Qdata1_ctl, Qdata0_ctl} == limit_ctl);

  ctl_state_e    state, state_nx;
  logic [PW-1:0] presc, presc_nx, presc_step;

  // Event priority inside each state: clear > stop > match > start
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_CLR:   state_nx = ST_IDLE;
      ST_IDLE:  if (clear_rise)      state_nx = ST_CLR;
                else if (start_rise) state_nx = ST_RUN;
      ST_RUN:   if (clear_rise)      state_nx = ST_CLR;
                else if (stop_rise)  state_nx = ST_PAUSE;
                else if (match)      state_nx = ST_DONE;
      ST_PAUSE: if (clear_rise)      state_nx = ST_CLR;
                else if (start_rise) state_nx = ST_RUN;
      ST_DONE:  if (clear_rise)      state_nx = ST_CLR;
      default:  state_nx = ST_CLR;
    endcase
  end

  assign presc_step = (presc == PRESC_LAST) ? '0 : presc + 1'b1;

  // The prescaler survives a pause so resuming does not add or lose part of a tick
  always_comb begin
    presc_nx = '0;
    if (state_nx == ST_RUN || state_nx == ST_PAUSE)
      presc_nx = (state == ST_RUN) ? presc_step : presc;
  end

  always_ff @(posedge clk_ctl) begin
    if (rstbutton_ctl) begin
      state <= ST_CLR;
      presc <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
    end
  end

  // Outputs are forced low for as long as reset is held
  assign ena0_ctl    = ~rstbutton_ctl & (state == ST_RUN) & (presc == PRESC_LAST) & ~match;
  assign clr_ctl     = ~rstbutton_ctl & (state == ST_CLR);
  assign running_ctl = ~rstbutton_ctl & (state == ST_RUN);
  assign done_ctl    = ~rstbutton_ctl & (state == ST_DONE);
  assign state_ctl   = rstbutton_ctl ? '0 : state;

endmodule
